// File: rtl/mdu.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready request and response.
// Define MDU_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle multiplier.
module mdu #(
  parameter  int XLEN = 32,
  localparam int CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_opcode,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result
);
  // Handshake: a request transfers on req_valid & req_ready (IDLE only); a response
  // transfers on resp_valid & resp_ready and resp_result holds until then.
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state;
  logic [CNTW-1:0]   cnt;
  logic [2:0]        op;
  logic              neg_q;
  logic              neg_r;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;

  logic              sgn1_en, sgn2_en, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf, fast_div;
  logic [XLEN-1:0]   fast_div_res;

  assign req_ready = (state == IDLE);

  assign sgn1_en = (req_opcode == 3'b001) || (req_opcode == 3'b010) ||
                   (req_opcode == 3'b100) || (req_opcode == 3'b110);
  assign sgn2_en = (req_opcode == 3'b001) || (req_opcode == 3'b100) || (req_opcode == 3'b110);
  assign s1      = sgn1_en & req_src1[XLEN-1];
  assign s2      = sgn2_en & req_src2[XLEN-1];
  assign mag1    = s1 ? -req_src1 : req_src1;
  assign mag2    = s2 ? -req_src2 : req_src2;

  assign div_zero = (req_src2 == '0);
  assign div_ovf  = ~req_opcode[0] && (req_src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&req_src2);
  assign fast_div = req_opcode[2] & (div_zero | div_ovf);
  assign fast_div_res = div_zero ? (req_opcode[1] ? req_src1 : '1)
                                 : (req_opcode[1] ? '0 : req_src1);

  // Restoring divide: acc holds {remainder, dividend bits still to shift in / quotient}.
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_nxt;
  logic [XLEN-1:0]   div_q, div_r, div_res;
  assign div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, opb};
  assign div_nxt   = div_trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                     : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  assign div_q     = div_nxt[XLEN-1:0];
  assign div_r     = div_nxt[2*XLEN-1:XLEN];
  assign div_res   = op[1] ? (neg_r ? -div_r : div_r) : (neg_q ? -div_q : div_q);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] ext1, ext2, fprod;
  logic [XLEN-1:0]   fast_mul_res;
  assign ext1  = {{XLEN{s1}}, req_src1};
  assign ext2  = {{XLEN{s2}}, req_src2};
  assign fprod = ext1 * ext2;
  assign fast_mul_res = (req_opcode[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  // Shift-add: acc holds {partial product, multiplier bits not yet consumed}.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt, mul_fix;
  logic [XLEN-1:0]   mul_res;
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_nxt = {mul_sum, acc[XLEN-1:1]};
  assign mul_fix = neg_q ? -mul_nxt : mul_nxt;
  assign mul_res = (op[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state       <= IDLE;
      cnt         <= '0;
      op          <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      opb         <= '0;
      acc         <= '0;
      resp_valid  <= 1'b0;
      resp_result <= '0;
    end else if (flush) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op    <= req_opcode;
          neg_q <= s1 ^ s2;
          neg_r <= s1;
          cnt   <= CNTW'(XLEN);
          if (req_opcode[2]) begin
            if (fast_div) begin
              state       <= DONE;
              resp_valid  <= 1'b1;
              resp_result <= fast_div_res;
            end else begin
              state <= DIV;
              opb   <= mag2;
              acc   <= {{XLEN{1'b0}}, mag1};
            end
          end else begin
`ifdef MDU_FAST_MUL_EN
            state       <= DONE;
            resp_valid  <= 1'b1;
            resp_result <= fast_mul_res;
`else
            state <= MUL;
            opb   <= mag1;
            acc   <= {{XLEN{1'b0}}, mag2};
`endif
          end
        end
`ifndef MDU_FAST_MUL_EN
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            state       <= DONE;
            resp_valid  <= 1'b1;
            resp_result <= mul_res;
          end
        end
`endif
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            state       <= DONE;
            resp_valid  <= 1'b1;
            resp_result <= div_res;
          end
        end
        DONE: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors, randomized ops against an arithmetic model,
// backpressure, flush and mid-operation reset.
module tb_mdu;
  localparam int XLEN = 32;
  localparam int DIV_LAT = XLEN + 1;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif

  logic            clk = 1'b0;
  logic            rst_b, flush, req_valid, req_ready, resp_valid, resp_ready;
  logic [2:0]      req_opcode;
  logic [XLEN-1:0] req_src1, req_src2, resp_result;

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  mdu #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_b(rst_b), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_src1(req_src1), .req_src2(req_src2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model written straight from the M-extension arithmetic rules.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return DIV_LAT;
  endfunction

  // ---- driver tasks ----
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_opcode = op; req_src1 = a; req_src2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_opcode = 3'($urandom); req_src1 = $urandom; req_src2 = $urandom;
  endtask

  // lat counts rising edges from the accept edge (inclusive) to resp_valid seen high.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_b = 1'b0;
    repeat (3) begin
      @(negedge clk);
      req_valid = 1'b1; req_opcode = 3'($urandom); req_src1 = $urandom; req_src2 = $urandom;
    end
    @(posedge clk); #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_vec++; if (resp_result !== '0) begin n_err++; $display("FAIL reset_resp_result: got %h expected 0", resp_result); end
    @(negedge clk);
    req_valid = 1'b0; rst_b = 1'b1;
  endtask

  logic [2:0]  d_op [15] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd5, 3'd7, 3'd4, 3'd6, 3'd0, 3'd3, 3'd6};
  logic [31:0] d_a  [15] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000,
                             32'h00010000, 32'h00010000, 32'hFFFFFFF9};
  logic [31:0] d_b  [15] = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2, 32'h2,
                             32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'h00010000, 32'h00010000, 32'h0};
  logic [31:0] d_exp[15] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h00000001,
                             32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h00000000,
                             32'h00000000, 32'h00000001, 32'hFFFFFFF9};
  int          d_lat[15] = '{MUL_LAT, MUL_LAT, MUL_LAT, MUL_LAT,
                             DIV_LAT, DIV_LAT, DIV_LAT, DIV_LAT,
                             1, 1, 1, 1, MUL_LAT, MUL_LAT, 1};

  task automatic test_directed();
    int lat;
    for (int i = 0; i < 15; i++) begin
      issue(d_op[i], d_a[i], d_b[i]);
      wait_resp(lat);
      n_vec++; if (resp_result !== d_exp[i]) begin n_err++; $display("FAIL directed_result[%0d]: got %h expected %h", i, resp_result, d_exp[i]); end
      n_vec++; if (lat != d_lat[i]) begin n_err++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, d_lat[i]); end
      consume();
      n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL directed_idle[%0d]: got ready=%b valid=%b expected 1/0", i, req_ready, resp_valid); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic rose;
    issue(3'd0, 32'd7, 32'd6);
    wait_resp(lat);
    n_vec++; if (resp_result !== 32'd42) begin n_err++; $display("FAIL bp_result: got %h expected %h", resp_result, 32'd42); end
    req_valid = 1'b1; req_opcode = 3'd5; req_src1 = 32'd99; req_src2 = 32'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_vec++; if (resp_valid !== 1'b1 || resp_result !== 32'd42 || req_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d]: got valid=%b result=%h ready=%b expected 1/%h/0", c, resp_valid, resp_result, req_ready, 32'd42);
      end
    end
    req_valid = 1'b0;
    consume();
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    rose = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (resp_valid === 1'b1) rose = 1'b1; end
    n_vec++; if (rose !== 1'b0) begin n_err++; $display("FAIL bp_no_stray_accept: got resp_valid rise=%b expected 0", rose); end
    issue(3'd5, 32'd100, 32'd7);
    wait_resp(lat);
    n_vec++; if (resp_result !== 32'd14 || lat != DIV_LAT) begin n_err++; $display("FAIL bp_next_op: got %h lat %0d expected %h lat %0d", resp_result, lat, 32'd14, DIV_LAT); end
    consume();
  endtask

  task automatic test_flush();
    int lat;
    logic rose;
    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_idle: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    rose = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid === 1'b1) rose = 1'b1; end
    n_vec++; if (rose !== 1'b0) begin n_err++; $display("FAIL flush_no_resp: got rise=%b expected 0", rose); end
    // flush and a request together in IDLE: the request must be dropped
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_opcode = 3'd0; req_src1 = 32'd9; req_src2 = 32'd9;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_err++; $display("FAIL flush_req_dropped: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    issue(3'd0, 32'd3, 32'd5);
    wait_resp(lat);
    n_vec++; if (resp_result !== 32'd15 || lat != MUL_LAT) begin n_err++; $display("FAIL flush_recover: got %h lat %0d expected %h lat %0d", resp_result, lat, 32'd15, MUL_LAT); end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    logic rose;
    issue(3'd1, 32'd1234, 32'd5678);
    repeat (10) @(posedge clk);
    #1 rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    n_vec++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_result !== '0) begin
      n_err++; $display("FAIL rstmid_state: got ready=%b valid=%b result=%h expected 1/0/0", req_ready, resp_valid, resp_result);
    end
    rose = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid === 1'b1) rose = 1'b1; end
    n_vec++; if (rose !== 1'b0) begin n_err++; $display("FAIL rstmid_no_resp: got rise=%b expected 0", rose); end
    issue(3'd0, 32'd3, 32'd5);
    wait_resp(lat);
    n_vec++; if (resp_result !== 32'd15 || lat != MUL_LAT) begin n_err++; $display("FAIL rstmid_recover: got %h lat %0d expected %h lat %0d", resp_result, lat, 32'd15, MUL_LAT); end
    consume();
  endtask

  task automatic test_random();
    int lat, elat, hold, sel;
    logic [2:0]  op;
    logic [31:0] a, b, e;
    for (int i = 0; i < 48; i++) begin
      op  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 7);
      a = $urandom; b = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (sel == 2) begin
        a = $urandom_range(0, 20); b = $urandom_range(1, 20);
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      exp_q.push_back(model(op, a, b));
      elat = model_lat(op, a, b);
      issue(op, a, b);
      wait_resp(lat);
      hold = $urandom_range(0, 2);
      repeat (hold) begin @(posedge clk); #1; end
      e = exp_q.pop_front();
      n_vec++; if (resp_result !== e || resp_valid !== 1'b1) begin
        n_err++; $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h valid=%b expected %h", i, op, a, b, resp_result, resp_valid, e);
      end
      n_vec++; if (lat != elat) begin n_err++; $display("FAIL random_latency[%0d] op=%0d: got %0d expected %0d", i, op, lat, elat); end
      consume();
    end
  endtask

  initial begin
    rst_b = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_opcode = '0; req_src1 = '0; req_src2 = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
